// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signal bundle for the FIFO write-port arbiter.
//
// Handshake: a requester holds req[i] high with its current word on its
// req_data slice. The word is consumed in the same cycle that ack[i] is high.
// The requester presents its next word after that clock edge. fifo_wr_enable
// and ack[grant_idx] are the same pulse, so every acknowledged word is a
// stored word.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int IDX_W  = 2,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    grant_valid;
    logic [IDX_W-1:0]        grant_idx;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_rd_enable;
    logic                    fifo_wr_enable;
    logic [DATA_W-1:0]       fifo_data_in;

    // Requesters and FIFO flags side.
    modport master (
        output req, req_data, fifo_full, fifo_empty, fifo_rd_enable,
        input  ack, grant_valid, grant_idx, fifo_wr_enable, fifo_data_in
    );

    // Arbiter side.
    modport slave (
        input  req, req_data, fifo_full, fifo_empty, fifo_rd_enable,
        output ack, grant_valid, grant_idx, fifo_wr_enable, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// A grant lasts up to BURST_MAX stored words. It is released earlier if the
// granted requester drops its request. One IDLE cycle separates grants.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_wr_arbiter_if.slave     bus,
    output logic                 dbg_state,
    output logic [IDX_W-1:0]     dbg_rr_ptr,
    output logic [CNT_W-1:0]     dbg_burst_cnt
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] burst_cnt;

    logic             wr_ok;
    logic             grant_valid;
    logic             req_granted;
    logic             wr_en;
    logic             release_grant;
    logic             any_req;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] next_ptr;

    // FIFO stores a write only when not full and no read takes the cycle.
    assign wr_ok         = !bus.fifo_full && !(bus.fifo_rd_enable && !bus.fifo_empty);
    assign grant_valid   = (state == GRANT);
    assign req_granted   = bus.req[grant_idx];
    assign wr_en         = grant_valid && req_granted && wr_ok;
    assign release_grant = grant_valid &&
                           ((wr_en && (burst_cnt == CNT_W'(BURST_MAX - 1))) || !req_granted);
    assign next_ptr      = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    assign bus.grant_valid    = grant_valid;
    assign bus.grant_idx      = grant_idx;
    assign bus.fifo_wr_enable = wr_en;

    assign dbg_state     = (state == GRANT);
    assign dbg_rr_ptr    = rr_ptr;
    assign dbg_burst_cnt = burst_cnt;

    // Forward the granted requester's slice; zero when nobody is granted.
    always_comb begin
        bus.fifo_data_in = '0;
        if (grant_valid) begin
            bus.fifo_data_in = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
        end
    end

    // Acknowledge only the granted requester, and only on a stored word.
    always_comb begin
        bus.ack = '0;
        if (wr_en) begin
            bus.ack[grant_idx] = 1'b1;
        end
    end

    // Pick the first requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!any_req && bus.req[j]) begin
                winner  = IDX_W'(j);
                any_req = 1'b1;
            end
        end
    end

    // Grant FSM: arbitrate in IDLE, count stored words in GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= GRANT;
                        grant_idx <= winner;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state     <= IDLE;
                        grant_idx <= '0;
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                    end else if (wr_en) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester word queues act as the
// requesters, and a negedge monitor scores writes and grants against queues.
module tb_fifo_wr_arbiter;
    localparam int N_REQ     = 4;
    localparam int IDX_W     = 2;
    localparam int DATA_W    = 16;
    localparam int BURST_MAX = 4;
    localparam int CNT_W     = 3;

    // Clock and reset.
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

    logic             dbg_state;
    logic [IDX_W-1:0] dbg_rr_ptr;
    logic [CNT_W-1:0] dbg_burst_cnt;

    fifo_wr_arbiter #(
        .N_REQ(N_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W),
        .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .dbg_state     (dbg_state),
        .dbg_rr_ptr    (dbg_rr_ptr),
        .dbg_burst_cnt (dbg_burst_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [IDX_W+DATA_W-1:0] exp_q[$];
    logic [IDX_W-1:0]        exp_grant_q[$];
    logic [DATA_W-1:0]       src_q[N_REQ][$];
    logic [N_REQ-1:0]        ack_s;
    logic                    gap_en = 1'b0;
    logic                    prev_gv = 1'b0;
    logic                    had_grant = 1'b0;
    int                      idle_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic load(input int idx, input logic [DATA_W-1:0] d);
        src_q[idx].push_back(d);
        exp_q.push_back({IDX_W'(idx), d});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        int  cyc;
        int  pending;
        logic done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            pending = 0;
            for (int i = 0; i < N_REQ; i++) pending += src_q[i].size();
            done = (exp_q.size() == 0) && (pending == 0) && !bus.grant_valid;
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    // Requester model: retire an acknowledged word, present the next one.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            bus.req[i] = (src_q[i].size() > 0);
            bus.req_data[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    end

    // Monitor: score every write and every new grant.
    always @(negedge clk) begin
        logic [IDX_W+DATA_W-1:0] e;
        logic [N_REQ-1:0]        oh;
        ack_s = bus.ack;
        if (bus.fifo_wr_enable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e[DATA_W +: IDX_W]] = 1'b1;
                check("wr_data", 32'(bus.fifo_data_in), 32'(e[DATA_W-1:0]));
                check("wr_ack", 32'(bus.ack), 32'(oh));
                check("wr_idx", 32'(bus.grant_idx), 32'(e[DATA_W +: IDX_W]));
                check("wr_legal", {30'd0, bus.fifo_full, bus.fifo_rd_enable && !bus.fifo_empty}, 32'd0);
            end
        end else if (bus.grant_valid) begin
            check("ack_without_write", 32'(bus.ack), 32'd0);
        end
        if (bus.grant_valid && !prev_gv) begin
            if (exp_grant_q.size() == 0) begin
                check("unexpected_grant", 32'(exp_grant_q.size()), 32'd1);
            end else begin
                check("grant_order", 32'(bus.grant_idx), 32'(exp_grant_q.pop_front()));
            end
            if (gap_en && had_grant) check("idle_gap", 32'(idle_run), 32'd1);
            had_grant = 1'b1;
            idle_run  = 0;
        end
        if (!bus.grant_valid) idle_run++;
        if (!gap_en) had_grant = 1'b0;
        prev_gv = bus.grant_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        bus.fifo_full      = 1'b0;
        bus.fifo_empty     = 1'b1;
        bus.fifo_rd_enable = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_wr_enable", 32'(bus.fifo_wr_enable), 32'd0);
        check("rst_data_in", 32'(bus.fifo_data_in), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        check("rst_burst_cnt", 32'(dbg_burst_cnt), 32'd0);
        rst_n = 1'b1;

        // Single requester: burst of 4, one idle cycle, re-grant for 2.
        @(posedge clk);
        for (int k = 0; k < 6; k++) load(0, 16'hA000 + 16'(k));
        exp_grant_q.push_back(2'd0);
        exp_grant_q.push_back(2'd0);
        @(negedge clk);
        check("t1_idle_before", 32'(bus.grant_valid), 32'd0);
        @(negedge clk);
        check("t1_grant_valid", 32'(bus.grant_valid), 32'd1);
        check("t1_grant_idx", 32'(bus.grant_idx), 32'd0);
        check("t1_first_write", 32'(bus.fifo_wr_enable), 32'd1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("t1_gap_idle", 32'(bus.grant_valid), 32'd0);
        check("t1_gap_rr_ptr", 32'(dbg_rr_ptr), 32'd1);
        check("t1_gap_burst_cnt", 32'(dbg_burst_cnt), 32'd0);
        @(negedge clk);
        check("t1_regrant", 32'(bus.grant_valid), 32'd1);
        check("t1_regrant_idx", 32'(bus.grant_idx), 32'd0);
        wait_drain();
        check("t1_end_rr_ptr", 32'(dbg_rr_ptr), 32'd1);

        // Round robin with all four requesting.
        do_reset();
        gap_en = 1'b1;
        @(posedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            for (int k = 0; k < 4; k++) load(i, 16'hB000 + 16'(i*16 + k));
            exp_grant_q.push_back(IDX_W'(i));
        end
        wait_drain();
        check("t2_rr_wrap", 32'(dbg_rr_ptr), 32'd0);
        gap_en = 1'b0;

        // Full stall on requester 2 after its first write.
        @(posedge clk);
        for (int k = 0; k < 4; k++) load(2, 16'hC000 + 16'(k));
        exp_grant_q.push_back(2'd2);
        @(posedge clk);
        @(posedge clk);
        #2 bus.fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("t3_stall_wr", 32'(bus.fifo_wr_enable), 32'd0);
            check("t3_stall_ack", 32'(bus.ack), 32'd0);
            check("t3_stall_grant", 32'(bus.grant_valid), 32'd1);
            check("t3_stall_idx", 32'(bus.grant_idx), 32'd2);
            check("t3_stall_burst", 32'(dbg_burst_cnt), 32'd1);
            @(posedge clk);
        end
        #2 bus.fifo_full = 1'b0;
        wait_drain();

        // Read collision on the first granted cycle of requester 0.
        @(posedge clk);
        load(0, 16'hD000);
        load(0, 16'hD001);
        exp_grant_q.push_back(2'd0);
        #2 bus.fifo_empty = 1'b0;
        @(posedge clk);
        #2 bus.fifo_rd_enable = 1'b1;
        @(negedge clk);
        check("t4_collide_wr", 32'(bus.fifo_wr_enable), 32'd0);
        check("t4_collide_ack", 32'(bus.ack), 32'd0);
        check("t4_collide_grant", 32'(bus.grant_valid), 32'd1);
        check("t4_collide_data", 32'(bus.fifo_data_in), 32'h0000D000);
        @(posedge clk);
        #2 bus.fifo_rd_enable = 1'b0;
        wait_drain();
        bus.fifo_empty = 1'b1;

        // Early release of requester 1 hands over to requester 3.
        @(posedge clk);
        load(1, 16'hE100);
        load(1, 16'hE101);
        load(3, 16'hE300);
        load(3, 16'hE301);
        exp_grant_q.push_back(2'd1);
        exp_grant_q.push_back(2'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_idle", 32'(bus.grant_valid), 32'd0);
        check("t5_rr_ptr", 32'(dbg_rr_ptr), 32'd2);
        @(negedge clk);
        check("t5_grant_valid", 32'(bus.grant_valid), 32'd1);
        check("t5_grant_idx", 32'(bus.grant_idx), 32'd3);
        wait_drain();

        // Reset during the second write of a burst to requester 1.
        @(posedge clk);
        for (int k = 0; k < 4; k++) src_q[1].push_back(16'hF100 + 16'(k));
        exp_q.push_back({2'd1, 16'hF100});
        exp_grant_q.push_back(2'd1);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_ack", 32'(bus.ack), 32'd0);
        check("t6_rst_wr", 32'(bus.fifo_wr_enable), 32'd0);
        check("t6_rst_grant", 32'(bus.grant_valid), 32'd0);
        @(negedge clk);
        load(0, 16'hF000);
        exp_q.push_back({2'd1, 16'hF101});
        exp_q.push_back({2'd1, 16'hF102});
        exp_q.push_back({2'd1, 16'hF103});
        exp_grant_q.push_back(2'd0);
        exp_grant_q.push_back(2'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain();

        check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's 16-bit synchronous FIFO among N_REQ requesters.
- Grants one requester at a time and forwards that requester's words into the FIFO.
- A grant lasts for a bounded burst of up to BURST_MAX accepted words.
- Sits directly in front of the FIFO's Data_in/wr_enable port. It observes the FIFO's full/empty flags and read strobe so that it acknowledges only the words the FIFO actually stores.

Parameters:
- N_REQ, 4, number of requesters.
- IDX_W, 2, width of the requester index; must equal clog2(N_REQ).
- DATA_W, 16, data width; matches the FIFO width.
- BURST_MAX, 4, maximum accepted writes per grant before a forced release.
- CNT_W, 3, width of the burst counter; must hold BURST_MAX.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester write request; level, held while the requester has data.
- req_data  in  N_REQ*DATA_W  packed data; requester i uses bits [i*DATA_W +: DATA_W].
- ack  out  N_REQ  one-hot pulse: the word on requester i's slice was written this cycle.
- grant_valid  out  1  a grant is active.
- grant_idx  out  IDX_W  index of the granted requester; 0 when no grant is active.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_enable  in  1  FIFO read strobe from the consumer.
- fifo_wr_enable  out  1  FIFO write strobe.
- fifo_data_in  out  DATA_W  FIFO write data.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, grant_idx=0, rr_ptr=0, burst_cnt=0.
  - ack=0, fifo_wr_enable=0, grant_valid=0, fifo_data_in=0.
  - Asserting reset mid-burst drops the grant immediately; the next cycle writes nothing.
- FIFO acceptance rule (fixed): the FIFO gives reads priority over writes.
  - wr_ok = !fifo_full && !(fifo_rd_enable && !fifo_empty).
- Combinational outputs, decoded from registered state:
  - grant_valid = (state==GRANT).
  - fifo_wr_enable = grant_valid && req[grant_idx] && wr_ok.
  - fifo_data_in = req_data slice of grant_idx while grant_valid, else 0.
  - ack[grant_idx] = fifo_wr_enable; all other ack bits are 0.
  - Zero-latency handshake: a word is consumed in the same cycle its ack is high. The requester advances its data on the next edge.
- FSM states: IDLE and GRANT.
- IDLE:
  - If any req bit is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Next edge: state=GRANT, grant_idx=winner, burst_cnt=0.
  - If no req bit is set, stay in IDLE.
- GRANT, each edge:
  - If fifo_wr_enable, burst_cnt increments.
  - Release when (fifo_wr_enable && burst_cnt==BURST_MAX-1) or !req[grant_idx].
  - On release: state=IDLE, rr_ptr=(grant_idx+1) mod N_REQ with wrap N_REQ-1 -> 0, burst_cnt=0.
  - On release grant_idx returns to 0; the no-grant value of grant_idx is 0.
  - Stalled (req held, !wr_ok): hold the grant with no timeout and do not increment burst_cnt.
- Arbitration latency:
  - Exactly one IDLE cycle between grants.
  - From req rising in IDLE to the first possible write: 1 cycle.
  - Maximum burst: BURST_MAX writes.
- Fairness:
  - With all requesters continuously requesting, grants rotate 0,1,2,3,0,...
  - A requester waits at most (N_REQ-1)*(BURST_MAX+1) non-stalled cycles plus 1 for its grant.
- Requests that change while another requester is granted do not preempt it; a new request is only seen in IDLE.
- The arbiter never writes when fifo_full=1. A FIFO read and an arbiter write never coincide.

Test Plan:
- Reset, single requester: rst_n low then high; req=0001, data0=0xA000..0xA005, FIFO empty, no reads.
  - Grant at cycle 1.
  - Writes 0xA000-0xA003 with ack[0] on 4 consecutive cycles.
  - 1 IDLE cycle, then a re-grant to 0; writes 0xA004, 0xA005.
- Round robin: req=1111 held, each requester supplying 4 words, ample FIFO space.
  - grant_idx sequence 0,1,2,3, each with 4 writes and one IDLE gap between grants.
  - rr_ptr wraps from 3 to 0.
- Full stall: granted to 2, fifo_full=1 for 3 cycles after 1 write.
  - fifo_wr_enable=0 and ack=0 for those 3 cycles; grant held; burst_cnt stays 1.
  - The remaining 3 writes follow once full drops.
- Read collision: granted, fifo_empty=0, fifo_rd_enable=1 for 1 cycle.
  - No write and no ack in that cycle.
  - The word is written next cycle with unchanged data.
- Early release: req[1] drops after 2 writes while req[3] is high.
  - Release; IDLE; grant to 3; rr_ptr=2 in the IDLE cycle.
- Mid-burst reset: rst_n=0 during the 2nd write of a burst to requester 1.
  - ack, fifo_wr_enable and grant_valid are 0 immediately.
  - After release, arbitration restarts from requester 0.
